// File: rtl/or64_unit.sv
// Registered bitwise-OR unit for the ALU logical group.
// Computes a | b plus zero and all-ones flags, one cycle after a valid strobe.
module or64_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             all_ones
);

    // Handshake: in_valid qualifies a/b for exactly the cycle it is high.
    // out_valid is high for exactly one cycle per accepted operation, one
    // clock later. There is no ready: the consumer always accepts.

    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             all_ones_q, all_ones_d;
    logic [WIDTH-1:0] or_val;

    always_comb begin
        or_val      = a | b;
        result_d    = result_q;
        zero_d      = zero_q;
        all_ones_d  = all_ones_q;
        out_valid_d = 1'b0;
        // Idle operands never reach the data path, so X there cannot leak out.
        if (in_valid) begin
            result_d    = or_val;
            zero_d      = (or_val == '0);
            all_ones_d  = &or_val;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            all_ones_q  <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            all_ones_q  <= all_ones_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign all_ones  = all_ones_q;

endmodule

// File: tb/tb_or64_unit.sv
// Directed, table-driven bench for or64_unit: each row is one clock of
// stimulus and the outputs expected just after that clock edge.
module tb_or64_unit;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         out_valid;
    logic         zero;
    logic         all_ones;

    int checks;
    int errors;

    or64_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .result   (result),
        .out_valid(out_valid),
        .zero     (zero),
        .all_ones (all_ones)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         vld;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         exp_valid;
        logic [W-1:0] exp_result;
        logic         exp_zero;
        logic         exp_ones;
    } vec_t;

    vec_t vecs[16];
    int   nvec;

    task automatic add_vec(input logic r, input logic v, input logic [W-1:0] va,
                           input logic [W-1:0] vb, input logic ev, input logic [W-1:0] er,
                           input logic ez, input logic eo);
        vecs[nvec].rst        = r;
        vecs[nvec].vld        = v;
        vecs[nvec].a          = va;
        vecs[nvec].b          = vb;
        vecs[nvec].exp_valid  = ev;
        vecs[nvec].exp_result = er;
        vecs[nvec].exp_zero   = ez;
        vecs[nvec].exp_ones   = eo;
        nvec++;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [W-1:0] er,
                                 input logic ez, input logic eo);
        checks++;
        if (out_valid !== ev) begin
            errors++;
            $display("FAIL %s out_valid got %b exp %b", tag, out_valid, ev);
        end
        checks++;
        if (result !== er) begin
            errors++;
            $display("FAIL %s result got %h exp %h", tag, result, er);
        end
        checks++;
        if (zero !== ez) begin
            errors++;
            $display("FAIL %s zero got %b exp %b", tag, zero, ez);
        end
        checks++;
        if (all_ones !== eo) begin
            errors++;
            $display("FAIL %s all_ones got %b exp %b", tag, all_ones, eo);
        end
    endtask

    // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
    task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] va,
                               input logic [W-1:0] vb);
        rst      = r;
        in_valid = v;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rnd;
        checks   = 0;
        errors   = 0;
        nvec     = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        // Reset held with a valid all-ones operation pending: it must be discarded.
        add_vec(1, 1, ONES, ONES, 0, 64'h0, 0, 0);
        add_vec(1, 1, ONES, ONES, 0, 64'h0, 0, 0);
        // Complementary patterns fill every bit.
        add_vec(0, 1, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1, ONES, 0, 1);
        // Idle with junk operands: outputs hold, valid drops.
        add_vec(0, 0, 64'hDEADBEEF00000000, 64'h0, 0, ONES, 0, 1);
        add_vec(0, 1, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 1, 64'hAAAAAAAAAAAAAAAA, 0, 0);
        add_vec(0, 1, 64'h0, 64'h0, 1, 64'h0, 1, 0);
        add_vec(0, 0, ONES, ONES, 0, 64'h0, 1, 0);
        add_vec(0, 1, 64'h0, 64'h1, 1, 64'h1, 0, 0);
        // Back-to-back stream of three operations.
        add_vec(0, 1, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 1, ONES, 0, 1);
        add_vec(0, 1, 64'h0, 64'h8000000000000000, 1, 64'h8000000000000000, 0, 0);
        add_vec(0, 1, 64'h123456789ABCDEF0, 64'h0, 1, 64'h123456789ABCDEF0, 0, 0);
        add_vec(0, 0, 64'h0, 64'h0, 0, 64'h123456789ABCDEF0, 0, 0);
        // Reset mid-stream with valid asserted, then the first op after release.
        add_vec(0, 1, ONES, 64'h0, 1, ONES, 0, 1);
        add_vec(1, 1, ONES, ONES, 0, 64'h0, 0, 0);
        add_vec(0, 1, 64'h00000000000000FF, 64'h000000000000FF00, 1, 64'h000000000000FFFF, 0, 0);
        add_vec(0, 0, ONES, 64'h0, 0, 64'h000000000000FFFF, 0, 0);

        for (int i = 0; i < nvec; i++) begin
            drive_cycle(vecs[i].rst, vecs[i].vld, vecs[i].a, vecs[i].b);
            check_outputs($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_result,
                          vecs[i].exp_zero, vecs[i].exp_ones);
        end

        // Hand sequence: one-hot walk streamed back-to-back; each bit alone is
        // neither zero nor all-ones (W > 1), then reset right after the stream.
        for (int i = 0; i < W; i += 9) begin
            rnd = '0;
            rnd[i] = 1'b1;
            drive_cycle(0, 1, (i % 2 == 0) ? rnd : 64'h0, (i % 2 == 0) ? 64'h0 : rnd);
            check_outputs($sformatf("walk%0d", i), 1'b1, rnd, 1'b0, 1'b0);
        end
        drive_cycle(1, 0, ONES, ONES);
        check_outputs("rst_after_walk", 1'b0, 64'h0, 1'b0, 1'b0);

        // Hand sequence: long idle gap after a zero result keeps the flags steady.
        drive_cycle(0, 1, 64'h0, 64'h0);
        check_outputs("zero_op", 1'b1, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 64'(i + 7), ONES);
            check_outputs($sformatf("zero_hold%0d", i), 1'b0, 64'h0, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
